// File: rtl/c17_rr_sched.sv
// Round-robin scheduler feeding one shared c17 stage with 2-credit result buffer.
// Optional perf counters: define C17_SCHED_PERF_EN.
module c17_rr_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [5*NREQ-1:0] req_data,
  input  logic              flush,
  output logic              c17_1,
  output logic              c17_2,
  output logic              c17_3,
  output logic              c17_6,
  output logic              c17_7,
  input  logic              c17_22,
  input  logic              c17_23,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [1:0]        rsp_data
`ifdef C17_SCHED_PERF_EN
  ,
  output logic [15:0]       perf_issued,
  output logic [15:0]       perf_stall
`endif
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_HOLD,
    ST_FLUSH
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic           r_s1_v;
  logic           r_s1_b7;
  logic [IDW-1:0] r_s1_id;
  logic [IDW-1:0] r_ptr;
  logic [1:0]     r_cnt;
  logic [IDW-1:0] r_h_id;
  logic [1:0]     r_h_d;
  logic [IDW-1:0] r_t_id;
  logic [1:0]     r_t_d;

  logic           w_pop;
  logic           w_push;
  logic [1:0]     w_occ;
  logic [1:0]     w_load;
  logic           w_can;
  logic           w_hit;
  logic [IDW-1:0] w_gid;
  logic           w_issue;
  logic [4:0]     w_slice;
  logic [1:0]     w_cnt_nxt;
  logic [1:0]     w_res;
  int             w_j;

  assign w_pop  = (r_cnt != 2'd0) & rsp_ready & ~flush;
  assign w_push = r_s1_v & ~flush;
  assign w_occ  = {1'b0, r_s1_v} + r_cnt;
  assign w_load = w_occ - {1'b0, w_pop};
  // A pop in this cycle hands its credit straight to a new issue.
  assign w_can  = reset_n & ~flush
                & (r_state != ST_FLUSH)
                & (w_load <= 2'd1);

  always_comb begin
    w_hit = 1'b0;
    w_gid = '0;
    w_j   = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_j = int'(r_ptr) + i;
      if (w_j >= NREQ) w_j = w_j - NREQ;
      if (!w_hit && req_valid[w_j]) begin
        w_hit = 1'b1;
        w_gid = IDW'(w_j);
      end
    end
  end

  assign w_issue = w_can & w_hit;
  assign w_slice = req_data[5*int'(w_gid) +: 5];
  assign w_res   = {c17_23, c17_22};

  assign req_ready = w_issue ? (NREQ'(1) << w_gid) : '0;
  assign c17_1     = w_issue & w_slice[0];
  assign c17_2     = w_issue & w_slice[1];
  assign c17_3     = w_issue & w_slice[2];
  assign c17_6     = w_issue & w_slice[3];
  assign c17_7     = r_s1_b7;
  assign rsp_valid = (r_cnt != 2'd0);
  assign rsp_id    = r_h_id;
  assign rsp_data  = r_h_d;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (flush) begin
      w_cnt_nxt = 2'd0;
    end else begin
      w_cnt_nxt = r_cnt + {1'b0, w_push}
                - {1'b0, w_pop};
    end
  end

  always_comb begin
    w_state_nxt = ST_RUN;
    unique case (1'b1)
      flush: w_state_nxt = ST_FLUSH;
      ((w_cnt_nxt + {1'b0, w_issue}) == 2'd2):
        w_state_nxt = ST_HOLD;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_RUN;
      r_s1_v  <= 1'b0;
      r_s1_b7 <= 1'b0;
      r_s1_id <= '0;
      r_ptr   <= '0;
      r_cnt   <= 2'd0;
      r_h_id  <= '0;
      r_h_d   <= 2'd0;
      r_t_id  <= '0;
      r_t_d   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_s1_v  <= w_issue;
      r_s1_b7 <= w_issue & w_slice[4];
      if (w_issue) begin
        r_s1_id <= w_gid;
        r_ptr   <= (w_gid == IDW'(NREQ-1))
                 ? '0 : w_gid + 1'b1;
      end
      r_cnt <= w_cnt_nxt;
      if (w_pop) begin
        r_h_id <= r_t_id;
        r_h_d  <= r_t_d;
      end
      // Head slot takes the push when empty or when it is draining.
      if (w_push) begin
        if (r_cnt == 2'd0 ||
            (r_cnt == 2'd1 && w_pop)) begin
          r_h_id <= r_s1_id;
          r_h_d  <= w_res;
        end else begin
          r_t_id <= r_s1_id;
          r_t_d  <= w_res;
        end
      end
    end
  end

`ifdef C17_SCHED_PERF_EN
  logic [15:0] r_perf_iss;
  logic [15:0] r_perf_stl;
  logic        w_stall;

  assign w_stall     = (|req_valid) & ~w_can;
  assign perf_issued = r_perf_iss;
  assign perf_stall  = r_perf_stl;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_iss <= 16'd0;
      r_perf_stl <= 16'd0;
    end else begin
      if (w_issue && r_perf_iss != 16'hFFFF)
        r_perf_iss <= r_perf_iss + 16'd1;
      if (w_stall && r_perf_stl != 16'hFFFF)
        r_perf_stl <= r_perf_stl + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_c17_rr_sched.sv
// Bench for c17_rr_sched: directed steps plus random traffic
// against a transaction-level model and a c17 datapath stub.
module tb_c17_rr_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [5*NREQ-1:0] req_data = '0;
  logic              flush = 1'b0;
  logic              c17_1, c17_2, c17_3, c17_6, c17_7;
  logic              c17_22, c17_23;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [IDW-1:0]    rsp_id;
  logic [1:0]        rsp_data;
`ifdef C17_SCHED_PERF_EN
  logic [15:0]       perf_issued;
  logic [15:0]       perf_stall;
`endif

  always #5 clock = ~clock;

  c17_rr_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .flush     (flush),
    .c17_1     (c17_1),
    .c17_2     (c17_2),
    .c17_3     (c17_3),
    .c17_6     (c17_6),
    .c17_7     (c17_7),
    .c17_22    (c17_22),
    .c17_23    (c17_23),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
`ifdef C17_SCHED_PERF_EN
    ,
    .perf_issued (perf_issued),
    .perf_stall  (perf_stall)
`endif
  );

  // c17 datapath stub: registered _1/_2/_3/_6, direct _7
  logic d1 = 1'b0, d2 = 1'b0, d3 = 1'b0, d6 = 1'b0;
  always @(posedge clock) begin
    d1 <= c17_1;
    d2 <= c17_2;
    d3 <= c17_3;
    d6 <= c17_6;
  end
  wire n10 = ~(d1 & d3);
  wire n11 = ~(d3 & d6);
  wire n16 = ~(d2 & n11);
  wire n19 = ~(n11 & c17_7);
  assign c17_22 = ~(n10 & n16);
  assign c17_23 = ~(n16 & n19);

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Sum-of-products form of the c17 outputs
  function automatic logic [1:0] ref_c17(input logic [4:0] v);
    logic r22, r23;
    r22 = (v[0] & v[2]) | (v[1] & ~(v[2] & v[3]));
    r23 = ~(v[2] & v[3]) & (v[1] | v[4]);
    return {r23, r22};
  endfunction

  typedef struct {
    logic [IDW-1:0] id;
    logic [1:0]     d;
    int             t;
  } exp_t;

  exp_t       q[$];
  exp_t       m_e;
  int         cyc = 0;
  int         m_ptr = 0;
  bit         m_fl = 1'b0;
  logic       m_s17 = 1'b0;
  bit         m_rv, m_pop, m_can, m_hit, m_iss;
  int         m_j;
  logic [4:0] m_dat;
  logic [3:0] m_rdy;

  // Transaction-level scoreboard sampled mid-cycle
  always @(negedge clock) begin
    cyc++;
    if (!reset_n) begin
      chk("rst_rdy", 32'(req_ready), 32'd0);
      chk("rst_rsp", 32'({rsp_valid, rsp_id, rsp_data}), 32'd0);
      chk("rst_c17", 32'({c17_7, c17_6, c17_3, c17_2, c17_1}), 32'd0);
      q.delete();
      m_ptr = 0;
      m_fl  = 1'b0;
      m_s17 = 1'b0;
    end else begin
      m_rv  = !m_fl && q.size() > 0 && (q[0].t + 2 <= cyc);
      chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
      if (m_rv) begin
        chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
        chk("rsp_data", 32'(rsp_data), 32'(q[0].d));
      end
      m_pop = m_rv && rsp_ready && !flush;
      m_can = !flush && !m_fl &&
              ((q.size() - int'(m_pop)) <= 1);
      m_hit = 1'b0;
      m_j   = 0;
      for (int i = 0; i < NREQ; i++) begin
        if (!m_hit && req_valid[(m_ptr + i) % NREQ]) begin
          m_hit = 1'b1;
          m_j   = (m_ptr + i) % NREQ;
        end
      end
      m_iss = m_can && m_hit;
      m_dat = req_data[m_j*5 +: 5];
      m_rdy = m_iss ? 4'(1 << m_j) : 4'd0;
      chk("req_ready", 32'(req_ready), 32'(m_rdy));
      chk("c17_in", 32'({c17_6, c17_3, c17_2, c17_1}),
          32'(m_iss ? m_dat[3:0] : 4'd0));
      chk("c17_7", 32'(c17_7), 32'(m_s17));
      if (m_pop) void'(q.pop_front());
      m_s17 = m_iss ? m_dat[4] : 1'b0;
      if (m_iss) begin
        m_e.id = IDW'(m_j);
        m_e.d  = ref_c17(m_dat);
        m_e.t  = cyc;
        q.push_back(m_e);
        m_ptr = (m_j + 1) % NREQ;
      end
      if (flush) q.delete();
      m_fl = flush;
    end
  end

  task automatic nxt;
    @(posedge clock);
    #1;
  endtask

  task automatic mid;
    @(negedge clock);
  endtask

  int g, r;

  initial begin
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;

    // single request, latency 2
    req_data[4:0] = 5'b00101;
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    mid;
    chk("s_rdy", 32'(req_ready), 32'd1);
    chk("s_c17in", 32'({c17_6, c17_3, c17_2, c17_1}), 32'b0101);
    nxt; req_valid = '0;
    mid;
    chk("s_lat1", 32'(rsp_valid), 32'd0);
    nxt; mid;
    chk("s_lat2", 32'(rsp_valid), 32'd1);
    chk("s_id", 32'(rsp_id), 32'd0);
    chk("s_data", 32'(rsp_data), 32'b01);
    nxt;

    // _7 alignment
    req_data[9:5] = 5'b10000;
    req_valid = 4'b0010;
    mid;
    chk("a_rdy", 32'(req_ready), 32'b0010);
    nxt; req_valid = '0;
    mid;
    chk("a_c17_7", 32'(c17_7), 32'd1);
    nxt; mid;
    chk("a_c17_7off", 32'(c17_7), 32'd0);
    chk("a_data", 32'(rsp_data), 32'b10);
    chk("a_id", 32'(rsp_id), 32'd1);
    nxt;
    req_data[9:5] = 5'b11110;
    req_valid = 4'b0010;
    mid;
    chk("b_rdy", 32'(req_ready), 32'b0010);
    nxt; req_valid = '0;
    mid;
    chk("b_c17_7", 32'(c17_7), 32'd1);
    nxt; mid;
    chk("b_data", 32'(rsp_data), 32'b00);
    nxt;

    // round robin, pointer now at 2
    req_data = 20'h9_A5C3;
    req_valid = 4'hF;
    for (int i = 0; i < 6; i++) begin
      mid;
      chk("rr_gnt", 32'(req_ready), 32'(1 << ((2 + i) % 4)));
      nxt;
    end
    req_valid = '0;
    repeat (4) begin mid; nxt; end

    // backpressure, pointer now at 0
    req_data = {4{5'b00010}};
    req_valid = 4'hF;
    rsp_ready = 1'b0;
    g = 0;
    for (int i = 0; i < 6; i++) begin
      mid;
      if (|req_ready) g++;
      if (i == 5) chk("bp_hold", 32'(req_ready), 32'd0);
      nxt;
    end
    chk("bp_issues", 32'(g), 32'd2);
    req_valid = '0;
    rsp_ready = 1'b1;
    r = 0;
    for (int i = 0; i < 4; i++) begin
      mid;
      if (rsp_valid) begin
        r++;
        chk("bp_data", 32'(rsp_data), 32'b11);
      end
      nxt;
    end
    chk("bp_drain", 32'(r), 32'd2);

    // flush with S1 valid and buffer occupied; pointer ends at 2
    req_valid = 4'b0011;
    rsp_ready = 1'b0;
    mid; nxt; mid; nxt;
    req_valid = '0;
    flush = 1'b1;
    mid;
    chk("f_pre_occ", 32'(rsp_valid), 32'd1);
    nxt;
    flush = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    mid;
    chk("f_rv", 32'(rsp_valid), 32'd0);
    chk("f_rdy", 32'(req_ready), 32'd0);
    nxt; mid;
    chk("f_ptr", 32'(req_ready), 32'b0100);
    nxt; req_valid = '0;
    mid;
    chk("f_lat1", 32'(rsp_valid), 32'd0);
    nxt; mid;
    chk("f_lat2", 32'(rsp_valid), 32'd1);
    chk("f_id", 32'(rsp_id), 32'd2);
    nxt;

    // random traffic
    for (int i = 0; i < 400; i++) begin
      req_valid = 4'($urandom);
      req_data  = 20'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      nxt;
    end
    flush = 1'b0;

    // reset with two results in flight
    req_valid = 4'hF;
    rsp_ready = 1'b0;
    nxt; nxt;
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_rdy", 32'(req_ready), 32'd0);
    chk("ar_rv", 32'(rsp_valid), 32'd0);
    chk("ar_c17", 32'({c17_7, c17_6, c17_3, c17_2, c17_1}), 32'd0);
    nxt;
    reset_n = 1'b1;
    mid;
    chk("ar_first", 32'(req_ready), 32'd1);
    nxt;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (4) nxt;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
